// File: rtl/video_mode_sequencer_if.sv
// Control/status bundle between the front-panel step logic and the video mode sequencer.
interface video_mode_sequencer_if;
   logic       frame_start_in;
   logic       bg_step_in;
   logic       target_step_in;
   logic       auto_en_in;
   logic       force_camera_in;
   logic [1:0] bg_sel_out;
   logic [1:0] target_sel_out;
   logic       mode_changed_out;
   logic       pending_out;

   modport master (
      output frame_start_in, bg_step_in, target_step_in, auto_en_in, force_camera_in,
      input  bg_sel_out, target_sel_out, mode_changed_out, pending_out
   );

   modport slave (
      input  frame_start_in, bg_step_in, target_step_in, auto_en_in, force_camera_in,
      output bg_sel_out, target_sel_out, mode_changed_out, pending_out
   );
endinterface

// File: rtl/video_mode_sequencer.sv
// Drives the background/overlay mux selects, applying requested mode changes only on
// frame boundaries, with auto-cycling, a post-change lockout and a force-camera override.
module video_mode_sequencer #(
   parameter int unsigned AUTO_FRAMES = 120,
   parameter int unsigned HOLD_FRAMES = 2
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   video_mode_sequencer_if.slave bus
);
   localparam int unsigned AUTO_W = $clog2(AUTO_FRAMES + 1);
   localparam int unsigned HOLD_W = (HOLD_FRAMES == 0) ? 1 : $clog2(HOLD_FRAMES + 1);
   localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_FRAMES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_LOCKOUT = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [1:0]          r_bg_sel;
   logic [1:0]          r_tg_sel;
   logic [1:0]          r_sh_bg;
   logic [1:0]          r_sh_tg;
   logic [AUTO_W-1:0]   r_auto_cnt;
   logic [HOLD_W-1:0]   r_hold_cnt;
   logic                r_changed;
   logic                r_pending;

   logic [1:0]          w_bg_nxt;
   logic [1:0]          w_tg_nxt;
   logic [1:0]          w_sh_bg_nxt;
   logic [1:0]          w_sh_tg_nxt;
   logic [AUTO_W-1:0]   w_auto_nxt;
   logic [HOLD_W-1:0]   w_hold_nxt;

   logic                w_fs;
   logic                w_force;
   logic                w_bg_step;
   logic                w_tg_step;
   logic                w_any_step;
   logic [1:0]          w_sh_bg_add;
   logic [1:0]          w_sh_tg_add;
   logic                w_force_hit;
   logic                w_auto_hit;
   logic                w_apply;
   logic                w_apply_diff;
   logic                w_change;
   logic                w_lock_done;

   assign w_fs    = bus.frame_start_in;
   assign w_force = bus.force_camera_in;

   // Steps are dropped while forced to camera or while locked out.
   assign w_bg_step  = bus.bg_step_in     & ~w_force & (r_state != ST_LOCKOUT);
   assign w_tg_step  = bus.target_step_in & ~w_force & (r_state != ST_LOCKOUT);
   assign w_any_step = w_bg_step | w_tg_step;

   assign w_sh_bg_add = w_force ? 2'b00 : r_sh_bg + {1'b0, w_bg_step};
   assign w_sh_tg_add = w_force ? 2'b00 : r_sh_tg + {1'b0, w_tg_step};

   assign w_force_hit  = w_force & w_fs & (|{r_bg_sel, r_tg_sel});
   assign w_auto_hit   = (r_state == ST_IDLE) & bus.auto_en_in & ~w_force & ~w_any_step
                         & w_fs & (r_auto_cnt == AUTO_LAST);
   assign w_apply      = (r_state == ST_PENDING) & w_fs;
   assign w_apply_diff = w_apply & ({w_sh_bg_add, w_sh_tg_add} != {r_bg_sel, r_tg_sel});
   assign w_change     = w_force_hit | w_auto_hit | w_apply_diff;
   assign w_lock_done  = (r_state == ST_LOCKOUT) & w_fs & (r_hold_cnt == HOLD_LAST);

   // State register
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; any applied change restarts the lockout window.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (w_any_step)  w_state_nxt = ST_PENDING;
         ST_PENDING: if (w_fs)        w_state_nxt = ST_IDLE;
         ST_LOCKOUT: if (w_lock_done) w_state_nxt = ST_IDLE;
         default:                     w_state_nxt = ST_IDLE;
      endcase
      if (w_change) begin
         w_state_nxt = (HOLD_FRAMES == 0) ? ST_IDLE : ST_LOCKOUT;
      end
   end

   // Next values for selects, shadows and frame counters.
   always_comb begin
      w_bg_nxt    = r_bg_sel;
      w_tg_nxt    = r_tg_sel;
      w_sh_bg_nxt = w_sh_bg_add;
      w_sh_tg_nxt = w_sh_tg_add;
      w_auto_nxt  = '0;
      w_hold_nxt  = r_hold_cnt;

      if (w_force_hit) begin
         w_bg_nxt = 2'b00;
         w_tg_nxt = 2'b00;
      end else if (w_auto_hit) begin
         w_tg_nxt = r_tg_sel + 2'd1;
      end else if (w_apply) begin
         w_bg_nxt = w_sh_bg_add;
         w_tg_nxt = w_sh_tg_add;
      end

      if (!w_force && ((r_state == ST_LOCKOUT) || w_auto_hit)) begin
         w_sh_bg_nxt = w_bg_nxt;
         w_sh_tg_nxt = w_tg_nxt;
      end

      if ((r_state == ST_IDLE) && bus.auto_en_in && !w_force && !w_any_step) begin
         w_auto_nxt = r_auto_cnt;
         if (w_fs) begin
            w_auto_nxt = w_auto_hit ? '0 : r_auto_cnt + AUTO_W'(1);
         end
      end

      if (w_change) begin
         w_hold_nxt = '0;
      end else if ((r_state == ST_LOCKOUT) && w_fs) begin
         w_hold_nxt = w_lock_done ? '0 : r_hold_cnt + HOLD_W'(1);
      end
   end

   // Datapath registers
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_bg_sel   <= 2'b00;
         r_tg_sel   <= 2'b00;
         r_sh_bg    <= 2'b00;
         r_sh_tg    <= 2'b00;
         r_auto_cnt <= '0;
         r_hold_cnt <= '0;
         r_changed  <= 1'b0;
         r_pending  <= 1'b0;
      end else begin
         r_bg_sel   <= w_bg_nxt;
         r_tg_sel   <= w_tg_nxt;
         r_sh_bg    <= w_sh_bg_nxt;
         r_sh_tg    <= w_sh_tg_nxt;
         r_auto_cnt <= w_auto_nxt;
         r_hold_cnt <= w_hold_nxt;
         r_changed  <= w_change;
         r_pending  <= (w_state_nxt == ST_PENDING);
      end
   end

   assign bus.bg_sel_out       = r_bg_sel;
   assign bus.target_sel_out   = r_tg_sel;
   assign bus.mode_changed_out = r_changed;
   assign bus.pending_out      = r_pending;

endmodule

// File: tb/tb_video_mode_sequencer.sv
// Bench for video_mode_sequencer: directed scenarios plus randomized traffic against a frame-level model.
module tb_video_mode_sequencer;
   localparam int AUTO = 3;
   localparam int HOLD = 2;
   localparam int MI = 0;
   localparam int MP = 1;
   localparam int ML = 2;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   video_mode_sequencer_if vif();

   video_mode_sequencer #(.AUTO_FRAMES(AUTO), .HOLD_FRAMES(HOLD)) dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .bus      (vif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [5:0] obs;
   assign obs = {vif.bg_sel_out, vif.target_sel_out, vif.mode_changed_out, vif.pending_out};

   // Reference model: mode, selects, shadows, frames seen while idle, frames left in lockout.
   int m_bg, m_tg, m_sb, m_st, m_mode, m_frames, m_lock_left;
   bit m_chg;

   task automatic model_reset();
      m_bg = 0; m_tg = 0; m_sb = 0; m_st = 0;
      m_mode = MI; m_frames = 0; m_lock_left = 0; m_chg = 0;
   endtask

   task automatic model_enter_lock();
      m_chg = 1;
      if (HOLD == 0) m_mode = MI;
      else begin m_mode = ML; m_lock_left = HOLD; end
   endtask

   task automatic model_lock_frame();
      m_lock_left = m_lock_left - 1;
      if (m_lock_left == 0) m_mode = MI;
   endtask

   task automatic model_clk(input bit fs, input bit bs, input bit ts, input bit ae, input bit fc);
      m_chg = 0;
      if (fc) begin
         m_sb = 0; m_st = 0; m_frames = 0;
         if (fs && (m_bg != 0 || m_tg != 0)) begin
            m_bg = 0; m_tg = 0; model_enter_lock();
         end else if (fs && m_mode == MP) m_mode = MI;
         else if (fs && m_mode == ML) model_lock_frame();
      end else if (m_mode == MI) begin
         if (bs || ts) begin
            m_sb = (m_sb + int'(bs)) % 4; m_st = (m_st + int'(ts)) % 4;
            m_mode = MP; m_frames = 0;
         end else if (!ae) m_frames = 0;
         else if (fs) begin
            m_frames++;
            if (m_frames == AUTO) begin
               m_frames = 0; m_tg = (m_tg + 1) % 4; m_st = m_tg; model_enter_lock();
            end
         end
      end else if (m_mode == MP) begin
         m_sb = (m_sb + int'(bs)) % 4; m_st = (m_st + int'(ts)) % 4;
         if (fs) begin
            if (m_sb != m_bg || m_st != m_tg) begin
               m_bg = m_sb; m_tg = m_st; model_enter_lock();
            end else m_mode = MI;
         end
      end else begin
         m_sb = m_bg; m_st = m_tg;
         if (fs) model_lock_frame();
      end
   endtask

   function automatic logic [5:0] model_obs();
      return {2'(m_bg), 2'(m_tg), m_chg, (m_mode == MP)};
   endfunction

   // One clock of stimulus; pulse inputs are cleared just after the edge.
   task automatic tick(input bit fs, input bit bs, input bit ts, input bit ae, input bit fc);
      vif.frame_start_in  = fs;
      vif.bg_step_in      = bs;
      vif.target_step_in  = ts;
      vif.auto_en_in      = ae;
      vif.force_camera_in = fc;
      @(posedge clk);
      model_clk(fs, bs, ts, ae, fc);
      #1;
      vif.frame_start_in = 1'b0;
      vif.bg_step_in     = 1'b0;
      vif.target_step_in = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      vif.frame_start_in = 1'b0; vif.bg_step_in = 1'b0; vif.target_step_in = 1'b0;
      vif.auto_en_in = 1'b0; vif.force_camera_in = 1'b0;
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (obs !== 6'b000000) begin errors++; $display("FAIL reset_hold: got %b want %b", obs, 6'b000000); end
      rst_n = 1'b1;
      tick(0, 0, 0, 0, 0);
      checks++; if (obs !== 6'b000000) begin errors++; $display("FAIL reset_release: got %b want %b", obs, 6'b000000); end
   endtask

   task automatic test_step_apply();
      tick(0, 0, 1, 0, 0);
      checks++; if (obs !== 6'b000001) begin errors++; $display("FAIL step_pending: got %b want %b", obs, 6'b000001); end
      tick(1, 0, 0, 0, 0);
      checks++; if (obs !== 6'b000110) begin errors++; $display("FAIL step_apply: got %b want %b", obs, 6'b000110); end
      tick(0, 0, 0, 0, 0);
      checks++; if (obs !== 6'b000100) begin errors++; $display("FAIL step_pulse_width: got %b want %b", obs, 6'b000100); end
   endtask

   task automatic test_lockout_drop();
      tick(0, 0, 1, 0, 0);
      checks++; if (obs !== 6'b000100) begin errors++; $display("FAIL lockout_drop: got %b want %b", obs, 6'b000100); end
      tick(1, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0);
      checks++; if (obs !== 6'b000100) begin errors++; $display("FAIL lockout_frames: got %b want %b", obs, 6'b000100); end
      tick(0, 0, 1, 0, 0);
      checks++; if (obs !== 6'b000101) begin errors++; $display("FAIL lockout_release_step: got %b want %b", obs, 6'b000101); end
      tick(1, 0, 0, 0, 0);
      checks++; if (obs !== 6'b001010) begin errors++; $display("FAIL lockout_third_frame: got %b want %b", obs, 6'b001010); end
      tick(1, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0);
   endtask

   task automatic test_step_wrap();
      for (int i = 0; i < 4; i++) tick(0, 1, 0, 0, 0);
      checks++; if (obs !== 6'b001001) begin errors++; $display("FAIL wrap_pending: got %b want %b", obs, 6'b001001); end
      tick(1, 0, 0, 0, 0);
      checks++; if (obs !== 6'b001000) begin errors++; $display("FAIL wrap_no_change: got %b want %b", obs, 6'b001000); end
      tick(0, 0, 1, 0, 0);
      checks++; if (obs !== 6'b001001) begin errors++; $display("FAIL wrap_idle_accepts: got %b want %b", obs, 6'b001001); end
   endtask

   task automatic test_auto_cycle();
      logic [5:0] exp;
      logic [1:0] tg;
      do_reset();
      for (int adv = 1; adv <= 4; adv++) begin
         for (int f = 1; f <= HOLD + AUTO; f++) begin
            tick(1, 0, 0, 1, 0);
            tg  = (f >= AUTO) ? 2'(adv) : 2'(adv - 1);
            exp = {2'b00, tg, (f == AUTO), 1'b0};
            checks++; if (obs !== exp) begin errors++; $display("FAIL auto_adv%0d_f%0d: got %b want %b", adv, f, obs, exp); end
            tick(0, 0, 0, 1, 0);
         end
      end
      checks++; if (obs !== 6'b000000) begin errors++; $display("FAIL auto_wrap: got %b want %b", obs, 6'b000000); end
   endtask

   task automatic test_force_camera();
      do_reset();
      tick(0, 1, 0, 0, 0); tick(0, 1, 0, 0, 0);
      tick(0, 0, 1, 0, 0); tick(0, 0, 1, 0, 0); tick(0, 0, 1, 0, 0);
      tick(1, 0, 0, 0, 0);
      checks++; if (obs !== 6'b101110) begin errors++; $display("FAIL force_setup: got %b want %b", obs, 6'b101110); end
      tick(0, 0, 0, 0, 1);
      checks++; if (obs !== 6'b101100) begin errors++; $display("FAIL force_waits_frame: got %b want %b", obs, 6'b101100); end
      tick(1, 0, 0, 0, 1);
      checks++; if (obs !== 6'b000010) begin errors++; $display("FAIL force_apply: got %b want %b", obs, 6'b000010); end
      tick(0, 1, 1, 0, 1);
      checks++; if (obs !== 6'b000000) begin errors++; $display("FAIL force_drop_steps: got %b want %b", obs, 6'b000000); end
      tick(1, 0, 0, 0, 1);
      checks++; if (obs !== 6'b000000) begin errors++; $display("FAIL force_zero_no_pulse: got %b want %b", obs, 6'b000000); end
      tick(1, 0, 0, 0, 1);
      tick(0, 0, 1, 0, 1);
      checks++; if (obs !== 6'b000000) begin errors++; $display("FAIL force_idle_drop: got %b want %b", obs, 6'b000000); end
      tick(0, 0, 1, 0, 0);
      checks++; if (obs !== 6'b000001) begin errors++; $display("FAIL force_release_step: got %b want %b", obs, 6'b000001); end
      tick(1, 0, 0, 0, 0);
      checks++; if (obs !== 6'b000110) begin errors++; $display("FAIL force_release_apply: got %b want %b", obs, 6'b000110); end
   endtask

   task automatic test_reset_mid_pending();
      do_reset();
      tick(0, 1, 0, 0, 0);
      tick(1, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0);
      tick(0, 1, 0, 0, 0);
      checks++; if (obs !== 6'b010001) begin errors++; $display("FAIL rst_mid_setup: got %b want %b", obs, 6'b010001); end
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      checks++; if (obs !== 6'b000000) begin errors++; $display("FAIL rst_mid_async: got %b want %b", obs, 6'b000000); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick(1, 0, 0, 0, 0);
      checks++; if (obs !== 6'b000000) begin errors++; $display("FAIL rst_mid_frame: got %b want %b", obs, 6'b000000); end
      tick(0, 0, 0, 0, 0);
      checks++; if (obs !== 6'b000000) begin errors++; $display("FAIL rst_mid_quiet: got %b want %b", obs, 6'b000000); end
   endtask

   task automatic test_random();
      bit ae, fc, fs, bs, ts;
      logic [5:0] exp;
      ae = 1'b0; fc = 1'b0;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 19) == 0) ae = ~ae;
         if ($urandom_range(0, 39) == 0) fc = ~fc;
         fs = ($urandom_range(0, 3) == 0);
         bs = ($urandom_range(0, 5) == 0);
         ts = ($urandom_range(0, 5) == 0);
         tick(fs, bs, ts, ae, fc);
         exp = model_obs();
         checks++; if (obs !== exp) begin errors++; $display("FAIL random_cycle%0d: got %b want %b", i, obs, exp); end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      vif.frame_start_in = 1'b0; vif.bg_step_in = 1'b0; vif.target_step_in = 1'b0;
      vif.auto_en_in = 1'b0; vif.force_camera_in = 1'b0;
      checks = 0;
      errors = 0;
      test_reset();
      test_step_apply();
      test_lockout_drop();
      test_step_wrap();
      test_auto_cycle();
      test_force_camera();
      test_reset_mid_pending();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
